// File: rtl/exec_ins_loader_pkg.sv
// Shared definitions for the executor instruction memory and its host loader:
// default RAM geometry, opcode constants and the loader state encoding.
package exec_ins_loader_pkg;

  // Default instruction RAM geometry
  localparam int INS_RAM_DATA_WIDTH = 64;
  localparam int INS_RAM_DEPTH      = 16;

  // Opcode byte lives in [7:0] of every instruction; INS_NONE terminates the executor
  localparam logic [7:0] INS_NONE  = 8'h00;
  localparam logic [7:0] INS_LOAD  = 8'h01;
  localparam logic [7:0] INS_STORE = 8'h02;
  localparam logic [7:0] INS_EXEC  = 8'h03;

  // Loader state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    DONE = ST_DONE
  } loader_state_e;

endpackage

// File: rtl/exec_ins_sdp_ram.sv
// Simple dual-port instruction RAM: one write port, one registered read port,
// plus an output register when RD_LAT == 2. Read-before-write on address collision.
module exec_ins_sdp_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_vld
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              rd_vld_q;

  // Storage array: write and registered read share one process so a colliding read sees old data
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_q <= mem_q[rd_addr];
    end
  end

  // First-stage valid strobe, one cycle behind the request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_oreg
      logic [DATA_W-1:0] dout_q;
      logic              vld_q;

      // Output register: captures only on a valid first stage so the data holds between reads
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_vld_q;
          if (rd_vld_q) begin
            dout_q <= rd_q;
          end
        end
      end

      assign rd_data = dout_q;
      assign rd_vld  = vld_q;
    end else begin : g_noreg
      logic seen_q;

      // The array register has no reset; mask it to zero until the first read after reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          seen_q <= 1'b0;
        end else if (rd_en) begin
          seen_q <= 1'b1;
        end
      end

      assign rd_data = seen_q ? rd_q : '0;
      assign rd_vld  = rd_vld_q;
    end
  endgenerate

endmodule

// File: rtl/exec_ins_loader.sv
// Executor instruction memory with host loader. Host words are packed
// little-end-first into DATA_W-bit instructions and written to an SDP RAM;
// the executor reads through a fixed-latency port.
// Optional build macro EXEC_IM_GUARD_EN: reads at or beyond loaded_cnt return
// an INS_NONE instruction instead of raw RAM contents.
module exec_ins_loader
  import exec_ins_loader_pkg::*;
#(
  parameter int DATA_W = INS_RAM_DATA_WIDTH,
  parameter int DEPTH  = INS_RAM_DEPTH,
  parameter int HOST_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic                     load_start_pulse,
  input  logic [$clog2(DEPTH):0]   load_ins_cnt,
  input  logic                     host_vld,
  input  logic [HOST_W-1:0]        host_data,
  output logic                     host_rdy,
  output logic                     load_done_pulse,
  output logic [$clog2(DEPTH):0]   loaded_cnt,
  output logic                     rd_err,
  input  logic                     im_rd_en,
  input  logic [$clog2(DEPTH)-1:0] im_rd_addr,
  output logic [DATA_W-1:0]        im_dout,
  output logic                     im_dout_vld
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WPI = DATA_W / HOST_W;
  localparam int WCW = (WPI > 1) ? $clog2(WPI) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  loader_state_e     state_q;
  logic [CW-1:0]     target_q;
  logic [CW-1:0]     ins_ptr_q;
  logic [CW-1:0]     loaded_cnt_q;
  logic [WCW-1:0]    word_cnt_q;
  logic [DATA_W-1:0] pack_q;
  logic [DATA_W-1:0] pack_d;
  logic              done_pulse_q;
  logic              rd_err_q;

  logic [CW-1:0]     start_target;
  logic              word_fire;
  logic              last_word;
  logic              wr_en;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_vld;

  // Requested count clamped to the RAM size
  assign start_target = (load_ins_cnt > DEPTH_C) ? DEPTH_C : load_ins_cnt;
  // A word presented together with a restart pulse is discarded
  assign word_fire    = host_vld && (state_q == LOAD) && !load_start_pulse;
  assign last_word    = (word_cnt_q == WCW'(WPI - 1));
  assign wr_en        = word_fire && last_word;

  // Next packed instruction: the current host word replaces slot word_cnt_q
  generate
    for (genvar gi = 0; gi < WPI; gi++) begin : g_pack
      assign pack_d[gi*HOST_W +: HOST_W] =
        (word_cnt_q == WCW'(gi)) ? host_data : pack_q[gi*HOST_W +: HOST_W];
    end
  endgenerate

  // Loader FSM with its counters and registered status outputs
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      target_q     <= '0;
      ins_ptr_q    <= '0;
      word_cnt_q   <= '0;
      pack_q       <= '0;
      loaded_cnt_q <= '0;
      done_pulse_q <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;

      if (load_start_pulse) begin
        rd_err_q <= 1'b0;
      end else if (im_rd_en && (state_q == LOAD)) begin
        rd_err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (load_start_pulse) begin
            target_q   <= start_target;
            ins_ptr_q  <= '0;
            word_cnt_q <= '0;
            state_q    <= (start_target == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (load_start_pulse) begin
            target_q   <= start_target;
            ins_ptr_q  <= '0;
            word_cnt_q <= '0;
            state_q    <= (start_target == '0) ? DONE : LOAD;
          end else if (word_fire) begin
            pack_q <= pack_d;
            if (last_word) begin
              word_cnt_q <= '0;
              ins_ptr_q  <= ins_ptr_q + CW'(1);
              if ((ins_ptr_q + CW'(1)) == target_q) begin
                state_q <= DONE;
              end
            end else begin
              word_cnt_q <= word_cnt_q + WCW'(1);
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          done_pulse_q <= 1'b1;
          loaded_cnt_q <= target_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_rdy        = (state_q == LOAD);
  assign load_done_pulse = done_pulse_q;
  assign loaded_cnt      = loaded_cnt_q;
  assign rd_err          = rd_err_q;

  exec_ins_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk     (clk),
    .rst     (sys_rst),
    .wr_en   (wr_en),
    .wr_addr (ins_ptr_q[AW-1:0]),
    .wr_data (pack_d),
    .rd_en   (im_rd_en),
    .rd_addr (im_rd_addr),
    .rd_data (ram_dout),
    .rd_vld  (ram_vld)
  );

  assign im_dout_vld = ram_vld;

`ifdef EXEC_IM_GUARD_EN
  logic oob_now;
  logic oob_out;
  logic oob0_q;

  assign oob_now = ({1'b0, im_rd_addr} >= loaded_cnt_q);

  // Out-of-range flag travels alongside the RAM read, holding between reads like the data
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      oob0_q <= 1'b0;
    end else if (im_rd_en) begin
      oob0_q <= oob_now;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_oob2
      logic vld1_q;
      logic oob1_q;

      // Second flag stage matching the RAM output register
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
          vld1_q <= 1'b0;
          oob1_q <= 1'b0;
        end else begin
          vld1_q <= im_rd_en;
          if (vld1_q) begin
            oob1_q <= oob0_q;
          end
        end
      end

      assign oob_out = oob1_q;
    end else begin : g_oob1
      assign oob_out = oob0_q;
    end
  endgenerate

  assign im_dout = oob_out ? {{(DATA_W-8){1'b0}}, INS_NONE} : ram_dout;
`else
  assign im_dout = ram_dout;
`endif

endmodule

// File: tb/tb_exec_ins_loader.sv
// Self-checking bench for exec_ins_loader: host loads driven from tasks,
// reads scored through an expected-result queue against a bench-side memory model.
module tb_exec_ins_loader;
  import exec_ins_loader_pkg::*;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int HOST_W = 32;
  localparam int RD_LAT = 2;
`ifdef EXEC_IM_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              sys_rst;
  logic              load_start_pulse;
  logic [4:0]        load_ins_cnt;
  logic              host_vld;
  logic [HOST_W-1:0] host_data;
  logic              host_rdy;
  logic              load_done_pulse;
  logic [4:0]        loaded_cnt;
  logic              rd_err;
  logic              im_rd_en;
  logic [3:0]        im_rd_addr;
  logic [DATA_W-1:0] im_dout;
  logic              im_dout_vld;

  always #5 clk = ~clk;

  exec_ins_loader #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .HOST_W (HOST_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk              (clk),
    .sys_rst          (sys_rst),
    .load_start_pulse (load_start_pulse),
    .load_ins_cnt     (load_ins_cnt),
    .host_vld         (host_vld),
    .host_data        (host_data),
    .host_rdy         (host_rdy),
    .load_done_pulse  (load_done_pulse),
    .loaded_cnt       (loaded_cnt),
    .rd_err           (rd_err),
    .im_rd_en         (im_rd_en),
    .im_rd_addr       (im_rd_addr),
    .im_dout          (im_dout),
    .im_dout_vld      (im_dout_vld)
  );

  typedef struct {
    logic [63:0] data;
    int          cyc;
    int          addr;
  } rd_exp_t;

  rd_exp_t     sb_q[$];
  logic [63:0] model_mem [DEPTH];
  int          model_loaded = 0;
  int          model_ptr = 0;
  int          model_wc = 0;
  logic [31:0] model_acc0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] exp_rd(input int a);
    if (GUARD && a >= model_loaded) return {56'h0, INS_NONE};
    return model_mem[a];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every valid strobe
  always @(negedge clk) begin
    rd_exp_t e;
    if (load_done_pulse) done_cnt++;
    if (im_dout_vld) begin
      if (sb_q.size() == 0) begin
        chk("spurious_vld", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        $display("read addr=%0d data=0x%016h issued@%0d seen@%0d", e.addr, im_dout, e.cyc, cyc);
        chk("rd_data", im_dout, e.data);
        chk("rd_lat", 64'(cyc - e.cyc), 64'(RD_LAT));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_word(input logic [31:0] w);
    if (model_wc == 0) begin
      model_acc0 = w;
      model_wc   = 1;
    end else begin
      model_mem[model_ptr] = {w, model_acc0};
      model_ptr++;
      model_wc = 0;
    end
  endtask

  task automatic start_load(input int cnt);
    load_start_pulse = 1'b1;
    load_ins_cnt     = 5'(cnt);
    tick;
    load_start_pulse = 1'b0;
    model_ptr = 0;
    model_wc  = 0;
    $display("load start cnt=%0d", cnt);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) tick;
    host_vld  = 1'b1;
    host_data = w;
    n = 0;
    while (!host_rdy && n < 20) begin
      tick;
      n++;
    end
    if (!host_rdy) chk("rdy_timeout", 64'(host_rdy), 64'(1));
    tick;
    host_vld = 1'b0;
    model_word(w);
  endtask

  task automatic wait_done(input int exp_cnt);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (load_done_pulse) found = 1'b1;
      tick;
    end
    chk("done_seen", 64'(found), 64'(1));
    chk("loaded_cnt", 64'(loaded_cnt), 64'(exp_cnt));
    model_loaded = exp_cnt;
    $display("load done loaded_cnt=%0d", loaded_cnt);
  endtask

  task automatic issue_rd(input int a);
    im_rd_en   = 1'b1;
    im_rd_addr = 4'(a);
    sb_q.push_back('{exp_rd(a), cyc, a});
    tick;
  endtask

  task automatic rd1(input int a);
    issue_rd(a);
    im_rd_en = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick;
      n++;
    end
    chk("sb_drain", 64'(sb_q.size()), 64'(0));
  endtask

  task automatic load_random(input int cnt, input int max_gap);
    start_load(cnt);
    for (int i = 0; i < 2 * ((cnt > DEPTH) ? DEPTH : cnt); i++) begin
      send_word($urandom(), int'($urandom_range(0, max_gap)));
    end
    wait_done((cnt > DEPTH) ? DEPTH : cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] t1_words [6];
    int d0;
    t1_words = '{32'h01, 32'h0A, 32'h02, 32'h0B, 32'h00, 32'h0C};

    sys_rst = 1'b1; load_start_pulse = 1'b0; load_ins_cnt = '0;
    host_vld = 1'b0; host_data = '0; im_rd_en = 1'b0; im_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_host_rdy", 64'(host_rdy), 64'(0));
    chk("rst_done", 64'(load_done_pulse), 64'(0));
    chk("rst_loaded_cnt", 64'(loaded_cnt), 64'(0));
    chk("rst_rd_err", 64'(rd_err), 64'(0));
    chk("rst_vld", 64'(im_dout_vld), 64'(0));
    chk("rst_dout", im_dout, 64'(0));
    sys_rst = 1'b0;
    tick;

    // Basic load of three instructions
    d0 = done_cnt;
    start_load(3);
    for (int i = 0; i < 6; i++) send_word(t1_words[i], 0);
    wait_done(3);
    repeat (3) tick;
    chk("done_once", 64'(done_cnt - d0), 64'(1));
    chk("rdy_after_done", 64'(host_rdy), 64'(0));
    rd1(1);
    drain;
    chk("t1_addr1", im_dout, 64'h0000000B_00000002);
    repeat (3) tick;
    chk("dout_hold", im_dout, 64'h0000000B_00000002);

    // Gapped host stream and back-to-back reads
    load_random(3, 3);
    issue_rd(0);
    issue_rd(1);
    issue_rd(2);
    im_rd_en = 1'b0;
    drain;

    // Zero-length load: straight to DONE, pulse two cycles after the start cycle
    start_load(0);
    chk("zero_rdy", 64'(host_rdy), 64'(0));
    chk("zero_done_early", 64'(load_done_pulse), 64'(0));
    tick;
    chk("zero_done", 64'(load_done_pulse), 64'(1));
    chk("zero_loaded", 64'(loaded_cnt), 64'(0));
    model_loaded = 0;
    tick;
    chk("zero_done_1cyc", 64'(load_done_pulse), 64'(0));

    // Oversized request clamps to DEPTH
    load_random(20, 0);
    for (int i = 0; i < 6; i++) rd1(int'($urandom_range(0, DEPTH - 1)));
    issue_rd(15);
    im_rd_en = 1'b0;
    drain;

    // Restart after one word; the word riding on the restart pulse is dropped
    start_load(2);
    send_word(32'h11, 0);
    load_start_pulse = 1'b1;
    load_ins_cnt     = 5'd1;
    host_vld         = 1'b1;
    host_data        = 32'hDEAD_BEEF;
    tick;
    load_start_pulse = 1'b0;
    host_vld         = 1'b0;
    model_ptr = 0;
    model_wc  = 0;
    send_word(32'h05, 0);
    send_word(32'h06, 0);
    wait_done(1);
    rd1(0);
    drain;
    chk("restart_addr0", im_dout, 64'h00000006_00000005);

    // Reset in the middle of a load
    d0 = done_cnt;
    start_load(4);
    for (int i = 0; i < 3; i++) send_word($urandom(), 0);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_host_rdy", 64'(host_rdy), 64'(0));
    chk("arst_loaded_cnt", 64'(loaded_cnt), 64'(0));
    chk("arst_dout", im_dout, 64'(0));
    chk("arst_vld", 64'(im_dout_vld), 64'(0));
    tick;
    sys_rst = 1'b0;
    model_loaded = 0;
    repeat (5) tick;
    chk("no_done_after_rst", 64'(done_cnt - d0), 64'(0));
    rd1(2);
    rd1(0);
    drain;

    // Read during LOAD, colliding with the write of the same address
    load_random(2, 0);
    start_load(1);
    send_word(32'hA5A5_0003, 0);
    host_vld   = 1'b1;
    host_data  = 32'h5A5A_1234;
    im_rd_en   = 1'b1;
    im_rd_addr = 4'd0;
    sb_q.push_back('{exp_rd(0), cyc, 0});
    tick;
    host_vld = 1'b0;
    im_rd_en = 1'b0;
    model_word(32'h5A5A_1234);
    chk("rd_err_set", 64'(rd_err), 64'(1));
    wait_done(1);
    chk("rd_err_sticky", 64'(rd_err), 64'(1));
    drain;
    rd1(0);
    drain;
    start_load(0);
    chk("rd_err_clear", 64'(rd_err), 64'(0));
    tick;
    model_loaded = 0;

    // Short load followed by an out-of-range read
    load_random(3, 1);
    rd1(5);
    drain;
`ifdef EXEC_IM_GUARD_EN
    chk("guard_opcode", 64'(im_dout[7:0]), 64'(INS_NONE));
    chk("guard_upper", 64'(im_dout[63:8]), 64'(0));
`else
    chk("raw_addr5", im_dout, model_mem[5]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_ins_loader.md
Name: exec_ins_loader

Overview:
- Instruction memory for the executor, plus a host-side loader that fills it.
- The host streams the instruction program as HOST_W-bit words. The block packs them into DATA_W-bit instructions and writes them to a simple dual-port RAM.
- The executor FSM reads the RAM through a fixed-latency port with a valid strobe.
- Sits between the host/DMA command path and the executor FSM.

Parameters:
- DATA_W, `INS_RAM_DATA_WIDTH, instruction width; integer multiple of HOST_W.
- DEPTH, `INS_RAM_DEPTH, instruction entries.
- HOST_W, 32, host word width.
- RD_LAT, 2, read latency from im_rd_en to im_dout_vld; legal values 1 or 2.

Ports:
- clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- load_start_pulse  in  1  begin a load; 1-cycle pulse
- load_ins_cnt  in  $clog2(DEPTH)+1  number of instructions to load; sampled on load_start_pulse
- host_vld  in  1  host word valid
- host_data  in  HOST_W  host word
- host_rdy  out  1  loader accepts a word this cycle
- load_done_pulse  out  1  load complete
- loaded_cnt  out  $clog2(DEPTH)+1  instructions written by the last load
- rd_err  out  1  sticky; a read was attempted while loading
- im_rd_en  in  1  read request
- im_rd_addr  in  $clog2(DEPTH)  read address
- im_dout  out  DATA_W  instruction
- im_dout_vld  out  1  im_dout valid; 1-cycle pulse

Behaviour:
- Reset values: every output is 0; state is IDLE. Reset does not clear RAM contents. Reset mid-load abandons the load; no done pulse is issued.
- States: IDLE, LOAD, DONE.
  - IDLE -> LOAD on load_start_pulse with target > 0.
  - IDLE -> DONE when target == 0.
  - LOAD -> DONE in the cycle the last instruction is written.
  - DONE -> IDLE unconditionally.
- Target: target = min(load_ins_cnt, DEPTH).
- Handshake: host_rdy = (state == LOAD). A word transfers when host_vld && host_rdy. host_vld while not ready is dropped silently.
- Packing:
  - WPI = DATA_W/HOST_W words per instruction.
  - Word k of an instruction lands in bits [k*HOST_W +: HOST_W], so the opcode byte [7:0] comes from the first word.
  - On the WPI-th word, the packed instruction (including that word) is written to RAM at ins_ptr. ins_ptr then increments and the word counter clears to 0.
- Completion: after a write with ins_ptr+1 == target, the FSM goes to DONE. load_done_pulse is asserted 1 cycle after entering DONE. loaded_cnt = target, updated in the same cycle as load_done_pulse.
- Restart: load_start_pulse in LOAD restarts the load. ins_ptr and the word counter clear, the partial instruction is discarded, and the new load_ins_cnt is sampled. A word presented in the same cycle is dropped.
- Read port:
  - im_dout_vld pulses exactly RD_LAT cycles after im_rd_en.
  - im_dout holds its value until the next valid.
  - Back-to-back reads are fully pipelined.
  - A read of the same address being written in the same cycle returns the old data.
- Reads during LOAD: the read is still performed. rd_err sets and stays set until the next load_start_pulse or reset.
- Out-of-range reads (im_rd_addr >= loaded_cnt): return raw RAM contents, unless the optional feature is enabled.

Optional Feature:
- Macro: EXEC_IM_GUARD_EN.
- Enabled: a read with im_rd_addr >= loaded_cnt returns zeros with [7:0] = `INS_NONE, at the same latency. The executor therefore always terminates, even on an unterminated program.
- Disabled: raw RAM data is returned; no comparator and no extra address pipeline.

Decomposition:
- Shared include (incl.vh): INS_RAM_DATA_WIDTH, INS_RAM_DEPTH, opcode constants including INS_NONE.
- Local state encoding as localparams.
- One sub-module, exec_ins_sdp_ram:
  - simple dual-port RAM, 1 write and 1 read port;
  - registered read, plus an optional output register selected by RD_LAT;
  - inferred BRAM.
- Packing FSM and guard logic live in the top module.

Test Plan (DATA_W=64, HOST_W=32, DEPTH=16, RD_LAT=2):
- Load 3 instructions, words 0x01,0xA,0x02,0xB,0x00,0xC. Expect: load_done_pulse once, loaded_cnt=3. Reading addr 1 gives im_dout=0x0000000B_00000002 with im_dout_vld 2 cycles after im_rd_en.
- Host words with host_vld gaps and back-to-back reads of addrs 0,1,2 on consecutive cycles. Expect: 3 consecutive vld pulses with in-order data.
- load_ins_cnt=0. Expect: no host_rdy, load_done_pulse 2 cycles after start, loaded_cnt=0. load_ins_cnt=20 clamps to loaded_cnt=16.
- Restart mid-instruction after 1 word, new cnt=1, words 0x05,0x6. Expect: addr 0 = 0x00000006_00000005.
- sys_rst asserted mid-load. Expect: outputs 0 asynchronously, no done pulse, previously loaded RAM data still readable. A read during a subsequent LOAD sets rd_err, which clears on the next load_start_pulse.
- With EXEC_IM_GUARD_EN, loaded_cnt=3, read addr 5. Expect: im_dout[7:0]=`INS_NONE, upper bits 0. Without the macro: raw RAM data.
